// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Handles the load-use bubble, downstream stall and branch/jump flush, and keeps two event counters.
module id_ex_stage_reg #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_ext_imm,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic [3:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic [1:0]    id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          stall_in,
  input  logic          flush,
  output logic          hazard_stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_ext_imm,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_rd,
  output logic [3:0]    ex_alu_op,
  output logic [1:0]    ex_reg_dst,
  output logic          ex_alu_src,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic [DW-1:0] inst_cnt,
  output logic [DW-1:0] bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] ext_imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [3:0]    alu_op;
    logic [1:0]    reg_dst;
    logic          alu_src;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
  } ex_pkt_t;

  ex_pkt_t       ex_q, ex_d, id_pkt;
  logic [DW-1:0] inst_cnt_q, inst_cnt_d;
  logic [DW-1:0] bubble_cnt_q, bubble_cnt_d;
  logic          load_use;

  // An empty ID slot still carries its data fields, but none of its side effects.
  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.pc         = id_pc;
    id_pkt.rs_data    = id_rs_data;
    id_pkt.rt_data    = id_rt_data;
    id_pkt.ext_imm    = id_ext_imm;
    id_pkt.rs         = id_rs;
    id_pkt.rt         = id_rt;
    id_pkt.rd         = id_rd;
    if (id_valid) begin
      id_pkt.alu_op     = id_alu_op;
      id_pkt.reg_dst    = id_reg_dst;
      id_pkt.alu_src    = id_alu_src;
      id_pkt.reg_write  = id_reg_write;
      id_pkt.mem_read   = id_mem_read;
      id_pkt.mem_write  = id_mem_write;
      id_pkt.mem_to_reg = id_mem_to_reg;
    end
  end

  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) & id_valid &
               ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
    hazard_stall = load_use & ~flush;
  end

  always_comb begin
    ex_d         = ex_q;
    inst_cnt_d   = inst_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall_in) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d         = '0;
      bubble_cnt_d = bubble_cnt_q + DW'(1);
    end else begin
      ex_d = id_pkt;
      if (id_valid) inst_cnt_d = inst_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= '0;
      inst_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      inst_cnt_q   <= inst_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_ext_imm    = ex_q.ext_imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign inst_cnt      = inst_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between decode (ID) and execute (EX) of the 5-stage MIPS pipeline.
- Captures the 32-bit immediate from the immediate extender, the register-file read data, the register indices and the decoded control bits.
- Detects load-use hazards against the instruction currently in EX and inserts bubbles.
- Handles downstream stall and branch/jump flush, and keeps two performance counters.

Parameters:
- DW, 32, datapath width (PC, operands, immediate, counters)
- AW, 5, register index width

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_pc  input  DW  PC of the ID instruction
- id_rs_data  input  DW  register-file read port A
- id_rt_data  input  DW  register-file read port B
- id_ext_imm  input  DW  extended immediate from the extender
- id_rs  input  AW  source index A
- id_rt  input  AW  source index B
- id_rd  input  AW  destination index (R-type)
- id_alu_op  input  4  ALU operation code
- id_alu_src  input  1  select immediate as ALU operand B
- id_reg_dst  input  2  write-index select (0 rt, 1 rd, 2 r31)
- id_reg_write  input  1  writes register file
- id_mem_read  input  1  load
- id_mem_write  input  1  store
- id_mem_to_reg  input  1  writeback from memory
- stall_in  input  1  downstream hold request
- flush  input  1  kill the instruction entering EX (taken branch/jump)
- hazard_stall  output  1  combinational; PC and IF/ID must hold
- ex_valid  output  1  EX holds a real instruction
- ex_pc, ex_rs_data, ex_rt_data, ex_ext_imm  output  DW each  registered copies
- ex_rs, ex_rt, ex_rd  output  AW each  registered copies
- ex_alu_op  output  4  registered copy
- ex_reg_dst  output  2  registered copy
- ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered copies
- inst_cnt  output  DW  valid instructions entered into EX
- bubble_cnt  output  DW  load-use bubbles inserted

Behaviour:
- Reset (async, rst=1): every registered output = 0, including ex_valid and both counters. Applies immediately, not at the next edge. Reset mid-operation discards the held instruction. First load occurs on the first rising edge after rst deasserts.
- load_use = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- hazard_stall = load_use & ~flush. It is purely combinational from current EX state and ID inputs, with no added latency.
- Per-edge action, strict priority:
  1. flush=1: bubble. ex_valid=0; all control outputs and all data/index outputs = 0. Flush overrides stall_in and load_use.
  2. stall_in=1: hold. All outputs keep their values and no counter changes. load_use is still evaluated on the held contents.
  3. load_use=1: bubble as in case 1; bubble_cnt += 1.
  4. Otherwise, load: every ex_* output takes its id_* counterpart. ex_valid = id_valid. If id_valid=0, control outputs are forced to 0 (data copied as-is). inst_cnt += 1 when id_valid=1.
- Invariant: ex_valid=0 implies ex_reg_write = ex_mem_read = ex_mem_write = ex_mem_to_reg = 0.
- Latency: exactly 1 cycle from ID input to EX output on a load. A load-use pair costs exactly 1 bubble. The dependent instruction enters EX on the following edge because the bubble clears ex_mem_read.
- Counters wrap modulo 2^DW (0xFFFFFFFF + 1 → 0). They are not cleared by flush; only rst clears them.
- Index 0 never causes a hazard. A load writing r0 followed by a use of r0 → no bubble.
- ex_ext_imm is passed through unmodified. No re-extension or width change happens here.

Test Plan:
- Reset: rst pulsed mid-cycle while ex_valid=1, ex_pc=0x00400010 → all outputs 0 immediately, before any clock edge. First edge after release loads ID.
- Plain load: id_valid=1, id_pc=0x00400000, id_ext_imm=0xFFFF8000, alu_src=1 → next edge ex_* match; inst_cnt=1; hazard_stall=0 throughout.
- Load-use: EX holds lw with ex_rt=8; ID has add with id_rs=8 → hazard_stall=1. Next edge: ex_valid=0, controls 0, bubble_cnt=1. Following edge: add enters EX, inst_cnt increments.
- r0 and no-dependency cases: EX lw ex_rt=0 with ID id_rs=0 → no bubble. EX lw ex_rt=9 with ID rs=3, rt=4 → no bubble.
- stall_in=1 for 3 cycles with ID changing → EX outputs and counters constant. Release → current ID value loads.
- flush=1 together with load_use=1 and stall_in=1 → bubble, hazard_stall=0, bubble_cnt unchanged. Counter preloaded to 0xFFFFFFFF with one more valid load → inst_cnt=0.
